bp_me_dma_wormhole_responder: RTL
=================================

# bp_me_dma_wormhole_responder

Memory-side endpoint of a DMA wormhole network link. It accepts request packets that a core tile's DMA socket injects. It performs the word reads or writes on a simple valid/ready memory port, then returns a response packet to the requesting coordinate. One request is in flight at a time. Packets are processed strictly in arrival order.

## Interface
- flit_width_p, 64: wormhole flit width; equals the memory data width.
- cord_width_p, 8: width of a network coordinate.
- len_width_p, 4: width of the wormhole length field.
- cid_width_p, 4: width of the concentrator/channel id.
- addr_width_p (localparam): flit_width_p - 2*cord_width_p - len_width_p - cid_width_p - 4. The default is 36.
- link_width_lp (localparam): flit_width_p+2. The packing is {v, data[flit_width_p], ready_and_rev}, most-significant first.

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-high reset.
- my_cord_i  in  cord_width_p  this endpoint's coordinate; placed in response src field.
- link_i  in  link_width_lp  inbound request flits, plus ready_and_rev for outbound responses.
- link_o  out  link_width_lp  outbound response flits, plus ready_and_rev for inbound requests.
- mem_v_o  out  1  memory command valid.
- mem_w_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  addr_width_p  byte address.
- mem_data_o  out  flit_width_p  write data.
- mem_ready_and_i  in  1  memory accepts the command.
- mem_data_v_i  in  1  read data valid; data returns in order.
- mem_data_i  in  flit_width_p  read data.
- mem_data_ready_and_o  out  1  responder accepts read data.

## Operation
- Header flit fields, LSB first:
  - dst cord [cord_width_p]
  - len [len_width_p]
  - src cord [cord_width_p]
  - cid [cid_width_p]
  - opcode [2]
  - size [2]
  - addr [addr_width_p]
- opcode[0]=1 means write and 0 means read. opcode[1] is reserved, ignored and echoed.
- Read: no data flits follow. Words = 1<<size (1, 2, 4 or 8).
  - Response is a header with len = words, followed by words data flits.
- Write: exactly len data flits follow. Words written = len, and size is ignored.
  - Response is a header only, with len = 0.
- Response header:
  - dst = request src
  - src = my_cord_i
  - cid, opcode, size and addr are echoed from the request.
- Word k uses address addr + k*(flit_width_p/8). The sum wraps modulo 2^addr_width_p.
- FSM states:
  - IDLE: link_o.ready_and_rev=1. A header handshake latches the fields and clears the word counter.
    - Read → RD_HDR.
    - Write with len>0 → WR_DATA.
    - Write with len=0 → WR_ACK.
  - WR_DATA: link_o.ready_and_rev = mem_ready_and_i. mem_v_o = link_i.v and mem_w_o=1. The data flit and memory write complete in the same cycle.
    - Each transfer increments the counter.
    - On the last word → WR_ACK.
  - WR_ACK: the ack header is valid on link_o. On link_i.ready_and_rev → IDLE.
  - RD_HDR: the response header is valid. On handshake → RD_CMD.
  - RD_CMD: mem_v_o=1 and mem_w_o=0 at the current address. On mem_ready_and_i → RD_DATA.
  - RD_DATA: link_o.v = mem_data_v_i, carrying mem_data_i, and mem_data_ready_and_o = link_i.ready_and_rev.
    - On handshake the counter increments.
    - If it was the last word → IDLE, otherwise → RD_CMD.
- link_o.ready_and_rev=0 in every state except IDLE and WR_DATA.
- mem_data_ready_and_o=0 outside RD_DATA. Read data arriving outside RD_DATA is a protocol violation, and the bench asserts on it.
- link_o.v must not deassert, and its data must not change, until the handshake completes.

## Timing
- Reset (asynchronous assert) forces:
  - state=IDLE, counter=0
  - link_o.v=0 and link_o.ready_and_rev=0 while reset_i is high
  - mem_v_o=0, mem_data_ready_and_o=0
  - data fields=0
- From the first clock edge after reset_i deasserts, link_o.ready_and_rev=1.
- Reset mid-packet abandons the packet. No response is produced, and partial writes already issued are not undone.
- Header accept at cycle T gives response header valid at T+1 (RD_HDR or WR_ACK, len=0).
- Write data flit accepted at cycle T means the memory write is issued in the same cycle T. There is zero added latency per word with no bubbles.
- Read word: command at C, data at D≥C+1, and the flit is forwarded combinationally in cycle D.
  - The minimum per-word interval is 2 cycles (RD_CMD, RD_DATA).
- Minimum back-to-back: the next header is accepted in the cycle after the final response flit handshake.
- Counter width is len_width_p. The write last-word compare is counter == len-1. The read last-word compare is counter == (1<<size)-1.

## Test plan
- Read, size=0, addr=0x100, src=0x12, cid=3, memory returns 0xDEAD_BEEF.
  - Required: header {dst=0x12, src=my_cord, len=1, cid=3} at T+1, then one flit 0xDEAD_BEEF, then back to IDLE.
- Write, len=4, addr=0x1000, data 1..4, mem_ready_and_i always 1.
  - Required: writes to 0x1000, 0x1008, 0x1010 and 0x1018 with data 1..4 on consecutive cycles, then an ack header with len=0.
- Read, size=3, random mem_data_v_i delays and random link_i.ready_and_rev stalls.
  - Required: 8 flits in address order, and link_o is stable while stalled.
- Write with len=0.
  - Required: no mem_v_o, and the ack header at T+1.
- Read with addr = 2^36-8, size=1.
  - Required: second address wraps to 0x0.
- reset_i pulsed mid-write (after 2 of 4 flits).
  - Required: all outputs are at reset values immediately, no ack is sent, and the next header is accepted normally.

Source files
------------

// File: rtl/bp_me_dma_wormhole_responder.sv
// Memory-side DMA wormhole endpoint: takes one request packet at a time, performs
// the word reads/writes on a valid/ready memory port and returns a response packet.
module bp_me_dma_wormhole_responder #(
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4,
  parameter int cid_width_p  = 4,
  localparam int addr_width_p  = flit_width_p - 2*cord_width_p - len_width_p - cid_width_p - 4,
  localparam int link_width_lp = flit_width_p + 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [cord_width_p-1:0]  my_cord_i,
  input  logic [link_width_lp-1:0] link_i,
  output logic [link_width_lp-1:0] link_o,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_p-1:0]  mem_addr_o,
  output logic [flit_width_p-1:0]  mem_data_o,
  input  logic                     mem_ready_and_i,
  input  logic                     mem_data_v_i,
  input  logic [flit_width_p-1:0]  mem_data_i,
  output logic                     mem_data_ready_and_o
);

  // Handshake rule on every channel: a transfer happens in a cycle where valid and
  // ready are both high; a raised valid holds its payload until that transfer.

  localparam int len_lo_lp  = cord_width_p;
  localparam int src_lo_lp  = len_lo_lp + len_width_p;
  localparam int cid_lo_lp  = src_lo_lp + cord_width_p;
  localparam int op_lo_lp   = cid_lo_lp + cid_width_p;
  localparam int size_lo_lp = op_lo_lp + 2;
  localparam int addr_lo_lp = size_lo_lp + 2;
  localparam int word_shift_lp = $clog2(flit_width_p/8);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_ACK, RD_HDR, RD_CMD, RD_DATA
  } state_e;

  state_e state_r, state_n;
  logic [len_width_p-1:0]  cnt_r, cnt_n, len_r;
  logic [cord_width_p-1:0] src_r;
  logic [cid_width_p-1:0]  cid_r;
  logic [1:0]              op_r, size_r;
  logic [addr_width_p-1:0] addr_r;

  logic                    in_v, out_ready, in_ready, out_v;
  logic [flit_width_p-1:0] in_data, out_data;
  logic [len_width_p-1:0]  in_len, rd_words, rd_last;
  logic [1:0]              in_op;

  assign in_v      = link_i[link_width_lp-1];
  assign in_data   = link_i[flit_width_p:1];
  assign out_ready = link_i[0];
  assign in_len    = in_data[src_lo_lp-1:len_lo_lp];
  assign in_op     = in_data[size_lo_lp-1:op_lo_lp];

  assign rd_words = len_width_p'(len_width_p'(1) << size_r);
  assign rd_last  = rd_words - len_width_p'(1);

  // Word k lives at addr + k*bytes_per_flit, wrapping in the address width.
  assign mem_addr_o = addr_r + (addr_width_p'(cnt_r) << word_shift_lp);

  // Request-side ready is forced low while reset is held.
  assign link_o = {out_v, out_data, in_ready & ~reset_i};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      len_r   <= '0;
      src_r   <= '0;
      cid_r   <= '0;
      op_r    <= '0;
      size_r  <= '0;
      addr_r  <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      if (state_r == IDLE && in_v) begin
        len_r  <= in_len;
        src_r  <= in_data[cid_lo_lp-1:src_lo_lp];
        cid_r  <= in_data[op_lo_lp-1:cid_lo_lp];
        op_r   <= in_op;
        size_r <= in_data[addr_lo_lp-1:size_lo_lp];
        addr_r <= in_data[flit_width_p-1:addr_lo_lp];
      end
    end
  end

  always_comb begin
    state_n              = state_r;
    cnt_n                = cnt_r;
    in_ready             = 1'b0;
    out_v                = 1'b0;
    out_data             = '0;
    mem_v_o              = 1'b0;
    mem_w_o              = 1'b0;
    mem_data_o           = '0;
    mem_data_ready_and_o = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        if (in_v) begin
          cnt_n = '0;
          if (!in_op[0])            state_n = RD_HDR;
          else if (in_len == '0)    state_n = WR_ACK;
          else                      state_n = WR_DATA;
        end
      end
      WR_DATA: begin
        // Data flit and memory write complete together, so ready comes from memory.
        in_ready   = mem_ready_and_i;
        mem_v_o    = in_v;
        mem_w_o    = 1'b1;
        mem_data_o = in_data;
        if (in_v && mem_ready_and_i) begin
          cnt_n = cnt_r + len_width_p'(1);
          if (cnt_r == len_r - len_width_p'(1)) state_n = WR_ACK;
        end
      end
      WR_ACK: begin
        out_v    = 1'b1;
        out_data = {addr_r, size_r, op_r, cid_r, my_cord_i, {len_width_p{1'b0}}, src_r};
        if (out_ready) state_n = IDLE;
      end
      RD_HDR: begin
        out_v    = 1'b1;
        out_data = {addr_r, size_r, op_r, cid_r, my_cord_i, rd_words, src_r};
        if (out_ready) state_n = RD_CMD;
      end
      RD_CMD: begin
        mem_v_o = 1'b1;
        if (mem_ready_and_i) state_n = RD_DATA;
      end
      RD_DATA: begin
        out_v                = mem_data_v_i;
        out_data             = mem_data_i;
        mem_data_ready_and_o = out_ready;
        if (mem_data_v_i && out_ready) begin
          cnt_n   = cnt_r + len_width_p'(1);
          state_n = (cnt_r == rd_last) ? IDLE : RD_CMD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
